// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - in-place radix-2 DIF FFT stage, address and write-back sequencer
// Ports:
//   clk, nrst            clock, synchronous active-low reset
//   start                request one FFT pass (sampled only while idle)
//   en                   global advance enable; 0 freezes FSM, counters and delay line
//   busy, done           pass in progress / one-cycle completion pulse
//   stage                current stage index
//   rd_en, rd_addr_a/b   butterfly read strobe and leg addresses
//   tw_addr, swap_en     twiddle ROM index and bank-steering select
//   wr_en, wr_addr_a/b   write-back strobe and addresses, read side delayed PIPE_LAT en cycles
module fft_stage_sequencer #(
   parameter int LOG2N    = 6,
   parameter int PIPE_LAT = 3
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             start,
   input  logic             en,
   output logic             busy,
   output logic             done,
   output logic [2:0]       stage,
   output logic             rd_en,
   output logic [LOG2N-1:0] rd_addr_a,
   output logic [LOG2N-1:0] rd_addr_b,
   output logic [LOG2N-2:0] tw_addr,
   output logic             swap_en,
   output logic             wr_en,
   output logic [LOG2N-1:0] wr_addr_a,
   output logic [LOG2N-1:0] wr_addr_b
);
   localparam int HALF = 1 << (LOG2N - 1);
   localparam int DW   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [LOG2N-1:0] SPAN0      = LOG2N'(HALF);
   localparam logic [DW-1:0]    DCNT_LAST  = DW'(PIPE_LAT - 1);
   localparam logic [2:0]       STAGE_LAST = 3'(LOG2N - 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t           state;
   logic [LOG2N-2:0] k;
   logic [DW-1:0]    dcnt;

   logic [LOG2N-1:0] k_ext;
   logic [LOG2N-1:0] span;
   logic [LOG2N-1:0] lo_mask;
   logic [LOG2N-1:0] addr_a;

   logic             pipe_v [PIPE_LAT];
   logic [LOG2N-1:0] pipe_a [PIPE_LAT];
   logic [LOG2N-1:0] pipe_b [PIPE_LAT];

   // Stage/drain schedule. READ walks k over all N/2 butterflies, DRAIN waits
   // out the datapath latency so every write of a stage lands before the next
   // stage reads it back.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state <= IDLE;
         k     <= '0;
         dcnt  <= '0;
         stage <= '0;
         done  <= 1'b0;
      end else begin
         // done is cleared every edge, even frozen ones, so it never stretches
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= READ;
                  stage <= '0;
                  k     <= '0;
               end
            end
            READ: begin
               if (en) begin
                  if (&k) begin
                     state <= DRAIN;
                     dcnt  <= '0;
                     k     <= '0;
                  end else begin
                     k <= k + (LOG2N-1)'(1);
                  end
               end
            end
            DRAIN: begin
               if (en) begin
                  if (dcnt == DCNT_LAST) begin
                     if (stage == STAGE_LAST) begin
                        state <= IDLE;
                        done  <= 1'b1;
                     end else begin
                        state <= READ;
                        stage <= stage + 3'd1;
                        k     <= '0;
                     end
                  end else begin
                     dcnt <= dcnt + DW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

   // Insert a zero at bit p = LOG2N-1-stage: bits of k at or above p move up
   // one place, bits below p stay. span is the single bit at position p.
   always_comb begin
      k_ext     = {1'b0, k};
      span      = SPAN0 >> stage;
      lo_mask   = span - LOG2N'(1);
      addr_a    = ((k_ext & ~lo_mask) << 1) | (k_ext & lo_mask);
      rd_en     = 1'b0;
      rd_addr_a = '0;
      rd_addr_b = '0;
      tw_addr   = '0;
      swap_en   = 1'b0;
      if (state == READ) begin
         rd_en     = en;
         rd_addr_a = addr_a;
         rd_addr_b = addr_a | span;
         tw_addr   = (addr_a[LOG2N-2:0] & lo_mask[LOG2N-2:0]) << stage;
         swap_en   = |(addr_a & span);
      end
   end

   // Write-back delay line; advances only on en so frozen reads stay aligned.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         for (int i = 0; i < PIPE_LAT; i++) begin
            pipe_v[i] <= 1'b0;
            pipe_a[i] <= '0;
            pipe_b[i] <= '0;
         end
      end else if (en) begin
         pipe_v[0] <= rd_en;
         pipe_a[0] <= rd_addr_a;
         pipe_b[0] <= rd_addr_b;
         for (int i = 1; i < PIPE_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
         end
      end
   end

   assign wr_en     = pipe_v[PIPE_LAT-1] & en;
   assign wr_addr_a = pipe_a[PIPE_LAT-1];
   assign wr_addr_b = pipe_b[PIPE_LAT-1];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb/tb_fft_stage_sequencer.sv - self-checking bench for fft_stage_sequencer
module tb_fft_stage_sequencer;
   localparam int LOG2N    = 6;
   localparam int PIPE_LAT = 3;
   localparam int HALF     = 32;
   localparam int STG_LEN  = HALF + PIPE_LAT;
   localparam int PASS_LEN = LOG2N * STG_LEN;

   logic       clk = 1'b0;
   logic       nrst, start, en;
   logic       busy, done, rd_en, swap_en, wr_en;
   logic [2:0] stage;
   logic [5:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [4:0] tw_addr;

   int n_cmp = 0;
   int n_bad = 0;
   int t_done = -1;

   typedef struct {
      bit v;
      int a;
      int b;
   } wb_t;
   wb_t exp_q[$];

   fft_stage_sequencer #(.LOG2N(LOG2N), .PIPE_LAT(PIPE_LAT)) dut (
      .clk(clk), .nrst(nrst), .start(start), .en(en),
      .busy(busy), .done(done), .stage(stage),
      .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .tw_addr(tw_addr), .swap_en(swap_en),
      .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
   );

   always #5 clk = ~clk;

   function automatic void ref_rd(input int st, input int k, output int a, output int b,
                                  output int tw, output int sw);
      int p;
      int span;
      p    = LOG2N - 1 - st;
      span = 1 << p;
      a    = ((k >> p) << (p + 1)) | (k & (span - 1));
      b    = a | span;
      tw   = ((a & (span - 1)) << st) % HALF;
      sw   = (a >> p) & 1;
   endfunction

   task automatic test_reset();
      nrst = 1'b0; start = 1'b0; en = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({busy, done, stage, rd_en, swap_en, wr_en, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b} !== '0) begin
         $display("FAIL reset_state: got busy=%b done=%b stage=%0d rd_en=%b wr_en=%b a=%0d b=%0d wa=%0d wb=%0d, expected all 0",
                  busy, done, stage, rd_en, wr_en, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b);
         n_bad++;
      end
      @(posedge clk); #1;
      nrst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_timing();
      int tab_c[4] = '{0, 5, 79, 182};
      int tab_a[4] = '{0, 5, 17, 14};
      int tab_b[4] = '{32, 37, 25, 15};
      int tab_t[4] = '{0, 5, 4, 0};
      int rd_a3 = -1, wr_a3 = -1, last_rd0 = -1, last_wr0 = -1, first_rd1 = -1, done_at = -1;
      start = 1'b1; en = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (cyc == tab_c[i]) begin
               n_cmp++;
               if ({rd_en, rd_addr_a, rd_addr_b, tw_addr} !== {1'b1, 6'(tab_a[i]), 6'(tab_b[i]), 5'(tab_t[i])}) begin
                  $display("FAIL addr_point cyc=%0d: got rd_en=%b a=%0d b=%0d tw=%0d, expected 1 a=%0d b=%0d tw=%0d",
                           cyc, rd_en, rd_addr_a, rd_addr_b, tw_addr, tab_a[i], tab_b[i], tab_t[i]);
                  n_bad++;
               end
            end
         end
         if (rd_en && stage == 3'd0 && rd_addr_a == 6'd3 && rd_a3 < 0) rd_a3 = cyc;
         if (wr_en && wr_addr_a == 6'd3 && wr_addr_b == 6'd35 && wr_a3 < 0) wr_a3 = cyc;
         if (rd_en && stage == 3'd0) last_rd0 = cyc;
         if (wr_en && wr_addr_a == 6'd31 && wr_addr_b == 6'd63) last_wr0 = cyc;
         if (rd_en && stage == 3'd1 && first_rd1 < 0) first_rd1 = cyc;
         if (done) begin
            done_at = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      n_cmp++;
      if (rd_a3 < 0 || wr_a3 - rd_a3 != PIPE_LAT) begin
         $display("FAIL latency: read a=3 at %0d, write a=3/b=35 at %0d, required distance %0d", rd_a3, wr_a3, PIPE_LAT);
         n_bad++;
      end
      n_cmp++;
      if (last_wr0 < 0 || first_rd1 < 0 || last_wr0 >= first_rd1) begin
         $display("FAIL hazard_order: last stage0 write at %0d, first stage1 read at %0d, required write first", last_wr0, first_rd1);
         n_bad++;
      end
      n_cmp++;
      if (first_rd1 - last_rd0 != PIPE_LAT + 1) begin
         $display("FAIL drain_gap: last stage0 read %0d, first stage1 read %0d, required gap %0d", last_rd0, first_rd1, PIPE_LAT + 1);
         n_bad++;
      end
      n_cmp++;
      if (done_at != PASS_LEN) begin
         $display("FAIL done_time: got %0d, required %0d", done_at, PASS_LEN);
         n_bad++;
      end
      t_done = done_at;
   endtask

   // Full pass against the model. The model tracks c, the count of en cycles
   // since the first READ cycle; reads occur for c%STG_LEN < HALF.
   task automatic run_pass(input int stall_c, input int stall_len, input bit noisy,
                           input bit chain, input bit started, output int done_at);
      int c = 0, stalled = 0, a, b, tw, sw, est;
      bit fin = 1'b0, rd_x, en_v, ebusy, edone;
      wb_t e;
      done_at = -1;
      exp_q = {};
      e.v = 1'b0; e.a = 0; e.b = 0;
      repeat (PIPE_LAT) exp_q.push_back(e);
      if (!started) begin
         start = 1'b1; en = 1'b1;
         @(negedge clk);
         n_cmp++;
         if ({busy, rd_en, wr_en} !== 3'b000) begin
            $display("FAIL start_cycle: got busy=%b rd_en=%b wr_en=%b, expected 000", busy, rd_en, wr_en);
            n_bad++;
         end
         @(posedge clk); #1;
         void'(exp_q.pop_front());
         exp_q.push_back(e);
      end
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
         en_v = 1'b1;
         if (c == stall_c && stalled < stall_len) begin
            en_v = 1'b0;
            stalled++;
         end
         if (c == PASS_LEN) en_v = (stall_len == 0);
         en    = en_v;
         start = (c == PASS_LEN) ? chain : (noisy ? ($urandom_range(0, 3) == 0) : 1'b0);
         rd_x  = (c < PASS_LEN) && (c % STG_LEN < HALF);
         a = 0; b = 0; tw = 0; sw = 0;
         if (rd_x) ref_rd(c / STG_LEN, c % STG_LEN, a, b, tw, sw);
         ebusy = (c < PASS_LEN);
         edone = (c == PASS_LEN);
         est   = (c < PASS_LEN) ? c / STG_LEN : LOG2N - 1;
         @(negedge clk);
         n_cmp++;
         if ({busy, done, stage, rd_en, swap_en, rd_addr_a, rd_addr_b, tw_addr} !==
             {ebusy, edone, 3'(est), rd_x & en_v, 1'(sw), 6'(a), 6'(b), 5'(tw)}) begin
            $display("FAIL pass_read c=%0d: got busy=%b done=%b stage=%0d rd_en=%b swap=%b a=%0d b=%0d tw=%0d, expected %b %b %0d %b %0d %0d %0d %0d",
                     c, busy, done, stage, rd_en, swap_en, rd_addr_a, rd_addr_b, tw_addr,
                     ebusy, edone, est, rd_x & en_v, sw, a, b, tw);
            n_bad++;
         end
         n_cmp++;
         if ({wr_en, wr_addr_a, wr_addr_b} !== {exp_q[0].v & en_v, 6'(exp_q[0].a), 6'(exp_q[0].b)}) begin
            $display("FAIL pass_write c=%0d: got wr_en=%b wa=%0d wb=%0d, expected %b %0d %0d",
                     c, wr_en, wr_addr_a, wr_addr_b, exp_q[0].v & en_v, exp_q[0].a, exp_q[0].b);
            n_bad++;
         end
         @(posedge clk); #1;
         if (en_v) begin
            void'(exp_q.pop_front());
            e.v = rd_x; e.a = a; e.b = b;
            exp_q.push_back(e);
         end
         if (c == PASS_LEN) begin
            fin = 1'b1;
            done_at = cyc;
         end else if (en_v) begin
            c++;
         end
      end
      start = 1'b0;
      en = 1'b1;
      n_cmp++;
      if (done_at != PASS_LEN + stall_len) begin
         $display("FAIL pass_done_time: got %0d, required %0d", done_at, PASS_LEN + stall_len);
         n_bad++;
      end
   endtask

   task automatic test_reset_midpass();
      int d;
      start = 1'b1; en = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (110) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (stage !== 3'd3) begin
         $display("FAIL midpass_stage: got %0d, required 3", stage);
         n_bad++;
      end
      nrst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         if (i == 1) nrst = 1'b1;
         @(negedge clk);
         n_cmp++;
         if ({busy, done, stage, rd_en, wr_en, wr_addr_a, wr_addr_b, rd_addr_a} !== '0) begin
            $display("FAIL midpass_reset%0d: got busy=%b done=%b stage=%0d rd_en=%b wr_en=%b wa=%0d wb=%0d, expected all 0",
                     i, busy, done, stage, rd_en, wr_en, wr_addr_a, wr_addr_b);
            n_bad++;
         end
      end
      @(posedge clk); #1;
      run_pass(-1, 0, 1'b0, 1'b0, 1'b0, d);
   endtask

   task automatic test_stall();
      int d;
      run_pass(4 * STG_LEN + 10, 5, 1'b0, 1'b0, 1'b0, d);
      n_cmp++;
      if (d - t_done != 5) begin
         $display("FAIL stall_delay: stalled done at %0d, unstalled %0d, required difference 5", d, t_done);
         n_bad++;
      end
      en = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({busy, done, wr_en, rd_en} !== 4'b0000) begin
         $display("FAIL after_done: got busy=%b done=%b wr_en=%b rd_en=%b, expected 0000", busy, done, wr_en, rd_en);
         n_bad++;
      end
      @(posedge clk); #1;
      en = 1'b1;
   endtask

   task automatic test_handshake();
      int d;
      run_pass(-1, 0, 1'b1, 1'b1, 1'b0, d);
      run_pass(-1, 0, 1'b0, 1'b0, 1'b1, d);
      @(negedge clk);
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         $display("FAIL handshake_idle: got busy=%b done=%b, expected 00", busy, done);
         n_bad++;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_timing();
      test_reset_midpass();
      test_stall();
      test_handshake();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
      $fatal(1);
   end
endmodule
